// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM bus-cycle sequencer: state encoding,
// counter/block widths and the block-select priority helper.
package sram_ctrl_pkg;

  localparam int WAIT_CNT_W = 4;
  localparam int NUM_BLOCKS = 4;

  // Bus-cycle phases, in the order a normal access walks through them.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    ACK     = 3'd3,
    RECOVER = 3'd4
  } state_e;

  // Keep only the lowest set bit: if the decoder ever raises more than one
  // block select, the lowest-numbered block wins.
  function automatic logic [NUM_BLOCKS-1:0] lowest_onehot(
    input logic [NUM_BLOCKS-1:0] sel
  );
    logic [NUM_BLOCKS-1:0] one;
    one = {{(NUM_BLOCKS-1){1'b0}}, 1'b1};
    return sel & (~sel + one);
  endfunction

endpackage

// File: rtl/sram_cycle_controller.sv
// 68k-to-SRAM bus-cycle sequencer: latches a request from the block decoder,
// runs SETUP / ACCESS (fixed wait states) / ACK / RECOVER, and drives chip
// enables, OE/WE, byte lanes and DTACK. Every output comes straight from a flop.
module sram_cycle_controller
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic                  Clock,
  input  logic                  Reset_L,
  input  logic                  AS_L,
  input  logic                  UDS_L,
  input  logic                  LDS_L,
  input  logic                  RW,
  input  logic [NUM_BLOCKS-1:0] Block_H,
  output logic [NUM_BLOCKS-1:0] SRam_CE_L,
  output logic                  SRam_OE_L,
  output logic                  SRam_WE_L,
  output logic                  SRam_UB_L,
  output logic                  SRam_LB_L,
  output logic                  Dtack_L,
  output logic                  Busy_H
);

  state_e                  state_q;
  logic [WAIT_CNT_W-1:0]   cnt_q;
  logic                    rw_q;
  logic [NUM_BLOCKS-1:0]   ce_l_q;
  logic                    oe_l_q;
  logic                    we_l_q;
  logic                    ub_l_q;
  logic                    lb_l_q;
  logic                    dtack_l_q;
  logic                    busy_q;

  logic                    req;
  logic [NUM_BLOCKS-1:0]   blk_sel;

  // A cycle starts only when the strobe, a block select and a data strobe coincide.
  assign req     = !AS_L && (|Block_H) && (!UDS_L || !LDS_L);
  assign blk_sel = lowest_onehot(Block_H);

  // Sequencer: state, wait counter, request latch and registered strobes.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rw_q      <= 1'b1;
      ce_l_q    <= '1;
      oe_l_q    <= 1'b1;
      we_l_q    <= 1'b1;
      ub_l_q    <= 1'b1;
      lb_l_q    <= 1'b1;
      dtack_l_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            // The strobe registers double as the request latch: later changes
            // on Block_H / UDS_L / LDS_L / RW are never looked at again.
            state_q   <= SETUP;
            rw_q      <= RW;
            ce_l_q    <= ~blk_sel;
            oe_l_q    <= ~RW;
            we_l_q    <= 1'b1;
            ub_l_q    <= UDS_L;
            lb_l_q    <= LDS_L;
            dtack_l_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end

        SETUP: begin
          if (AS_L) begin
            state_q   <= RECOVER;
            ce_l_q    <= '1;
            oe_l_q    <= 1'b1;
            we_l_q    <= 1'b1;
            ub_l_q    <= 1'b1;
            lb_l_q    <= 1'b1;
            dtack_l_q <= 1'b1;
          end else begin
            state_q <= ACCESS;
            cnt_q   <= WAIT_CNT_W'(WAIT_STATES);
            // Address and CE have had a full cycle to settle; open WE now.
            we_l_q  <= rw_q;
          end
        end

        ACCESS: begin
          if (AS_L) begin
            // CPU gave up on the cycle: drop everything, never acknowledge.
            state_q   <= RECOVER;
            ce_l_q    <= '1;
            oe_l_q    <= 1'b1;
            we_l_q    <= 1'b1;
            ub_l_q    <= 1'b1;
            lb_l_q    <= 1'b1;
            dtack_l_q <= 1'b1;
          end else if (cnt_q == '0) begin
            // WE rises while CE stays low so the SRAM gets data hold time.
            state_q   <= ACK;
            we_l_q    <= 1'b1;
            dtack_l_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ACK: begin
          if (AS_L) begin
            state_q   <= RECOVER;
            ce_l_q    <= '1;
            oe_l_q    <= 1'b1;
            we_l_q    <= 1'b1;
            ub_l_q    <= 1'b1;
            lb_l_q    <= 1'b1;
            dtack_l_q <= 1'b1;
          end
        end

        RECOVER: begin
          // One dead cycle; a request pending here is only seen from IDLE.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q   <= IDLE;
          ce_l_q    <= '1;
          oe_l_q    <= 1'b1;
          we_l_q    <= 1'b1;
          ub_l_q    <= 1'b1;
          lb_l_q    <= 1'b1;
          dtack_l_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign SRam_CE_L = ce_l_q;
  assign SRam_OE_L = oe_l_q;
  assign SRam_WE_L = we_l_q;
  assign SRam_UB_L = ub_l_q;
  assign SRam_LB_L = lb_l_q;
  assign Dtack_L   = dtack_l_q;
  assign Busy_H    = busy_q;

endmodule

// File: tb/tb_sram_cycle_controller.sv
// Self-checking bench for sram_cycle_controller. The main instance
// (WAIT_STATES=1) is checked cycle by cycle against an expected-output queue
// filled when each request is driven; two extra instances (0 and 15 wait
// states) share the inputs and are used for DTACK latency checks.
module tb_sram_cycle_controller;

  localparam int W = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       as_l, uds_l, lds_l, rw;
  logic [3:0] blk;

  logic [3:0] ce_l, ce0, ce15;
  logic       oe_l, we_l, ub_l, lb_l, dtack_l, busy;
  logic       oe0, we0, ub0, lb0, dtack0, busy0;
  logic       oe15, we15, ub15, lb15, dtack15, busy15;
  logic [9:0] obs;

  logic [9:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  // {CE_L[3:0], OE_L, WE_L, UB_L, LB_L, Dtack_L, Busy_H}
  assign obs = {ce_l, oe_l, we_l, ub_l, lb_l, dtack_l, busy};

  sram_cycle_controller #(.WAIT_STATES(W)) u_dut (
    .Clock(clk), .Reset_L(rst_n), .AS_L(as_l), .UDS_L(uds_l), .LDS_L(lds_l),
    .RW(rw), .Block_H(blk), .SRam_CE_L(ce_l), .SRam_OE_L(oe_l),
    .SRam_WE_L(we_l), .SRam_UB_L(ub_l), .SRam_LB_L(lb_l),
    .Dtack_L(dtack_l), .Busy_H(busy)
  );

  sram_cycle_controller #(.WAIT_STATES(0)) u_w0 (
    .Clock(clk), .Reset_L(rst_n), .AS_L(as_l), .UDS_L(uds_l), .LDS_L(lds_l),
    .RW(rw), .Block_H(blk), .SRam_CE_L(ce0), .SRam_OE_L(oe0),
    .SRam_WE_L(we0), .SRam_UB_L(ub0), .SRam_LB_L(lb0),
    .Dtack_L(dtack0), .Busy_H(busy0)
  );

  sram_cycle_controller #(.WAIT_STATES(15)) u_w15 (
    .Clock(clk), .Reset_L(rst_n), .AS_L(as_l), .UDS_L(uds_l), .LDS_L(lds_l),
    .RW(rw), .Block_H(blk), .SRam_CE_L(ce15), .SRam_OE_L(oe15),
    .SRam_WE_L(we15), .SRam_UB_L(ub15), .SRam_LB_L(lb15),
    .Dtack_L(dtack15), .Busy_H(busy15)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [3:0] pick_low(input logic [3:0] b);
    if (b[0]) return 4'b0001;
    else if (b[1]) return 4'b0010;
    else if (b[2]) return 4'b0100;
    else if (b[3]) return 4'b1000;
    return 4'b0000;
  endfunction

  // Expected outputs k cycles after the request edge, AS_L released during cycle rel.
  function automatic logic [9:0] exp_vec(input int k, input int rel, input logic [3:0] b,
                                         input logic r, input logic u, input logic l);
    logic we_e;
    logic dt_e;
    if (k == rel + 2) return 10'b1111_1111_10;   // IDLE
    if (k == rel + 1) return 10'b1111_1111_11;   // RECOVER
    we_e = (k >= 1 && k <= W + 1 && !r) ? 1'b0 : 1'b1;
    dt_e = (k >= W + 2) ? 1'b0 : 1'b1;
    return {~pick_low(b), !r, we_e, u, l, dt_e, 1'b1};
  endfunction

  // Compare the main instance against the queue head once per cycle, clear of edges.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) check_eq("cycle", 32'(obs), 32'(exp_q.pop_front()));
    end
  end

  // Drive one bus cycle starting at a falling edge; return in the RECOVER cycle.
  task automatic run_txn(input logic [3:0] b, input logic r, input logic u, input logic l,
                         input int rel, input bit early);
    as_l = 1'b0; blk = b; rw = r; uds_l = u; lds_l = l;
    if (early) @(negedge clk);
    for (int k = 0; k <= rel + 2; k++) exp_q.push_back(exp_vec(k, rel, b, r, u, l));
    $display("txn blk=%b rw=%0b uds_l=%0b lds_l=%0b hold=%0d early=%0b", b, r, u, l, rel, early);
    for (int k = 0; k <= rel; k++) begin
      @(negedge clk);
      if (k < rel) begin
        blk = 4'($urandom); uds_l = 1'($urandom); lds_l = 1'($urandom); rw = 1'($urandom);
      end else begin
        as_l = 1'b1; blk = 4'b0000; uds_l = 1'b1; lds_l = 1'b1; rw = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check_eq("drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic watch_dtack(input string tag, input bit use15, input int want);
    int lat;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #2;
      if ((use15 ? dtack15 : dtack0) === 1'b0) begin
        lat = k;
        break;
      end
    end
    check_eq(tag, 32'(lat), 32'(want));
  endtask

  initial begin
    logic [3:0] rb;
    logic       rr, ru, rl;
    rst_n = 1'b0; as_l = 1'b1; uds_l = 1'b1; lds_l = 1'b1; rw = 1'b1; blk = 4'b0000;
    repeat (3) @(negedge clk);
    check_eq("rst_main", 32'(obs), 32'h3FE);
    check_eq("rst_w0", 32'({ce0, oe0, we0, ub0, lb0, dtack0, busy0}), 32'h3FE);
    check_eq("rst_w15", 32'({ce15, oe15, we15, ub15, lb15, dtack15, busy15}), 32'h3FE);
    rst_n = 1'b1;
    @(negedge clk);

    // Read, both lanes, block 2.
    run_txn(4'b0100, 1'b1, 1'b0, 1'b0, 4, 1'b0); drain();
    // Write lower byte only, block 0.
    run_txn(4'b0001, 1'b0, 1'b1, 1'b0, 3, 1'b0); drain();

    // DTACK latency at the wait-state extremes.
    fork
      run_txn(4'b1000, 1'b1, 1'b0, 1'b0, 20, 1'b0);
      watch_dtack("lat_w0", 1'b0, 2);
      watch_dtack("lat_w15", 1'b1, 17);
    join
    drain();
    check_eq("w0_idle", 32'(busy0), 32'd0);
    check_eq("w15_idle", 32'(busy15), 32'd0);

    // Aborts: AS_L released in ACCESS (write), then in SETUP (read).
    run_txn(4'b0010, 1'b0, 1'b0, 1'b0, 1, 1'b0); drain();
    run_txn(4'b1000, 1'b1, 1'b0, 1'b1, 0, 1'b0); drain();

    // Asynchronous reset in the middle of ACCESS.
    as_l = 1'b0; blk = 4'b0100; rw = 1'b0; uds_l = 1'b0; lds_l = 1'b0;
    $display("txn reset-abort blk=%b write", blk);
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    check_eq("pre_rst_we", 32'(we_l), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_eq("async_rst", 32'(obs), 32'h3FE);
    @(negedge clk);
    rst_n = 1'b1; as_l = 1'b1; blk = 4'b0000; uds_l = 1'b1; lds_l = 1'b1; rw = 1'b1;
    @(negedge clk);
    check_eq("post_rst_idle", 32'(obs), 32'h3FE);
    run_txn(4'b0100, 1'b1, 1'b0, 1'b0, 3, 1'b0); drain();

    // Back-to-back: new request presented during RECOVER, two blocks selected.
    run_txn(4'b0001, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    run_txn(4'b0110, 1'b1, 1'b0, 1'b0, 3, 1'b1);
    drain();

    // A few random cycles.
    for (int t = 0; t < 6; t++) begin
      rb = 4'($urandom_range(1, 15));
      rr = 1'($urandom);
      ru = 1'($urandom);
      rl = ru ? 1'b0 : 1'($urandom);
      run_txn(rb, rr, ru, rl, $urandom_range(0, 6), 1'b0);
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
